// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and coordinate type for the VGA timing generator.
// Defaults describe 640x480@60 Hz from a 25 MHz pixel clock.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;

    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int DEF_FRAME_W   = 8;

    localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    typedef logic [COORD_W-1:0] coord_t;

    // Half-open window test lo <= value < hi, used for the sync pulse decodes.
    function automatic logic in_window(input coord_t value, input int lo, input int hi);
        return (value >= coord_t'(lo)) && (value < coord_t'(hi));
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis counter: counts 0..COUNT_MAX on each inc, and exposes the
// value it will hold after the next edge so the top can decode outputs in step.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int COUNT_MAX = H_TOTAL - 1
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   inc,
    output coord_t count,
    output coord_t next_count,
    output logic   wrap
);

    localparam coord_t LAST = coord_t'(COUNT_MAX);

    coord_t count_reg;
    coord_t count_next;
    logic   wrap_next;

    always_comb begin
        wrap_next  = inc && (count_reg == LAST);
        count_next = count_reg;
        if (reset) begin
            count_next = '0;
        end else if (wrap_next) begin
            count_next = '0;
        end else if (inc) begin
            count_next = count_reg + coord_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count      = count_reg;
    assign next_count = count_next;
    assign wrap       = wrap_next;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: DrawX/DrawY coordinates plus blank, syncs, line/frame
// pulses and a frame counter, all registered and cycle-aligned with the coordinates.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int FRAME_W   = DEF_FRAME_W
) (
    input  logic               vga_clk,
    input  logic               reset,
    output logic [COORD_W-1:0] DrawX,
    output logic [COORD_W-1:0] DrawY,
    output logic               blank,
    output logic               hs,
    output logic               vs,
    output logic               line_end,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int LINE_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int FRAME_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_VIS_END  = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS_END  = coord_t'(V_VISIBLE);
    localparam coord_t H_LAST     = coord_t'(LINE_TOTAL - 1);
    localparam int     HS_START   = H_VISIBLE + H_FRONT;
    localparam int     HS_END     = H_VISIBLE + H_FRONT + H_SYNC;
    localparam int     VS_START   = V_VISIBLE + V_FRONT;
    localparam int     VS_END     = V_VISIBLE + V_FRONT + V_SYNC;

    coord_t hc;
    coord_t vc;
    coord_t hc_next;
    coord_t vc_next;
    logic   h_wrap;
    logic   v_wrap;

    vga_axis_counter #(
        .COUNT_MAX (LINE_TOTAL - 1)
    ) u_h_counter (
        .clk        (vga_clk),
        .reset      (reset),
        .inc        (1'b1),
        .count      (hc),
        .next_count (hc_next),
        .wrap       (h_wrap)
    );

    vga_axis_counter #(
        .COUNT_MAX (FRAME_TOTAL - 1)
    ) u_v_counter (
        .clk        (vga_clk),
        .reset      (reset),
        .inc        (h_wrap),
        .count      (vc),
        .next_count (vc_next),
        .wrap       (v_wrap)
    );

    logic               blank_reg;
    logic               hs_reg;
    logic               vs_reg;
    logic               line_end_reg;
    logic               frame_start_reg;
    logic [FRAME_W-1:0] frame_count_reg;

    logic               blank_next;
    logic               hs_next;
    logic               vs_next;
    logic               line_end_next;
    logic               frame_start_next;
    logic [FRAME_W-1:0] frame_count_next;

    // Decode from the counters' next values so the registered flags land on
    // the same edge as the coordinates they describe.
    always_comb begin
        blank_next       = (hc_next < H_VIS_END) && (vc_next < V_VIS_END);
        hs_next          = !in_window(hc_next, HS_START, HS_END);
        vs_next          = !in_window(vc_next, VS_START, VS_END);
        line_end_next    = (hc_next == H_LAST);
        frame_start_next = h_wrap && v_wrap;
        frame_count_next = frame_count_reg;
        if (frame_start_next) begin
            frame_count_next = frame_count_reg + FRAME_W'(1);
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            blank_reg       <= 1'b1;
            hs_reg          <= 1'b1;
            vs_reg          <= 1'b1;
            line_end_reg    <= 1'b0;
            frame_start_reg <= 1'b0;
            frame_count_reg <= '0;
        end else begin
            blank_reg       <= blank_next;
            hs_reg          <= hs_next;
            vs_reg          <= vs_next;
            line_end_reg    <= line_end_next;
            frame_start_reg <= frame_start_next;
            frame_count_reg <= frame_count_next;
        end
    end

    assign DrawX       = hc;
    assign DrawY       = vc;
    assign blank       = blank_reg;
    assign hs          = hs_reg;
    assign vs          = vs_reg;
    assign line_end    = line_end_reg;
    assign frame_start = frame_start_reg;
    assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for line-level timing, plus a tiny
// 15x8 raster instance so whole-frame, frame-wrap and 256-frame checks stay short.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a;
    logic       rst_b;
    logic [9:0] x_a, y_a, x_b, y_b;
    logic       blank_a, hs_a, vs_a, le_a, fs_a;
    logic       blank_b, hs_b, vs_b, le_b, fs_b;
    logic [7:0] fc_a, fc_b;

    vga_timing_gen u_dut_a (
        .vga_clk     (clk),
        .reset       (rst_a),
        .DrawX       (x_a),
        .DrawY       (y_a),
        .blank       (blank_a),
        .hs          (hs_a),
        .vs          (vs_a),
        .line_end    (le_a),
        .frame_start (fs_a),
        .frame_count (fc_a)
    );

    // Small mode: H 8+2+3+2 = 15 (hs low at 10..12), V 4+1+2+1 = 8 (vs low on lines 5..6).
    vga_timing_gen #(
        .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
        .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (1),
        .FRAME_W   (8)
    ) u_dut_b (
        .vga_clk     (clk),
        .reset       (rst_b),
        .DrawX       (x_b),
        .DrawY       (y_b),
        .blank       (blank_b),
        .hs          (hs_b),
        .vs          (vs_b),
        .line_end    (le_b),
        .frame_start (fs_b),
        .frame_count (fc_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag, input logic [9:0] x, input logic [9:0] y,
                                    input logic bl, input logic h, input logic v,
                                    input logic le, input logic fs, input logic [7:0] fc);
        check_eq({tag, "_x"}, x, 0);
        check_eq({tag, "_y"}, y, 0);
        check_eq({tag, "_blank"}, bl, 1);
        check_eq({tag, "_hs"}, h, 1);
        check_eq({tag, "_vs"}, v, 1);
        check_eq({tag, "_line_end"}, le, 0);
        check_eq({tag, "_frame_start"}, fs, 0);
        check_eq({tag, "_frame_count"}, fc, 0);
        $display("txn %s: (%0d,%0d) blank=%0b hs=%0b vs=%0b fc=%0d", tag, x, y, bl, h, v, fc);
    endtask

    task automatic wait_a(input int x, input int y, input string tag);
        int budget;
        budget = 10000;
        while (!(x_a == 10'(x) && y_a == 10'(y)) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_eq({tag, "_reached"}, 32'(x_a == 10'(x) && y_a == 10'(y)), 1);
    endtask

    // Independent raster model for the small instance.
    int bx, by, bf;

    task automatic step_b();
        logic wrapped;
        wrapped = (bx == 14) && (by == 7);
        @(negedge clk);
        if (bx == 14) begin
            bx = 0;
            by = (by == 7) ? 0 : by + 1;
        end else begin
            bx++;
        end
        if (wrapped) bf = (bf + 1) % 256;
        check_eq("b_x", x_b, bx);
        check_eq("b_y", y_b, by);
        check_eq("b_blank", blank_b, 32'(bx < 8 && by < 4));
        check_eq("b_hs", hs_b, 32'(!(bx >= 10 && bx <= 12)));
        check_eq("b_vs", vs_b, 32'(!(by >= 5 && by <= 6)));
        check_eq("b_line_end", le_b, 32'(bx == 14));
        check_eq("b_frame_start", fs_b, 32'(wrapped));
        check_eq("b_frame_count", fc_b, bf);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Test 1 (default mode): three reset cycles then release.
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        check_reset_vals("a_release", x_a, y_a, blank_a, hs_a, vs_a, le_a, fs_a, fc_a);
        @(negedge clk);
        check_eq("a_first_count_x", x_a, 1);
        check_eq("a_first_count_y", y_a, 0);
        check_eq("a_first_count_blank", blank_a, 1);

        // Test 2: whole of line 0, blank edge at 640 and hs window 656..751.
        for (int x = 2; x <= 799; x++) begin
            @(negedge clk);
            check_eq("a_l0_x", x_a, x);
            check_eq("a_l0_y", y_a, 0);
            check_eq("a_l0_blank", blank_a, 32'(x < 640));
            check_eq("a_l0_hs", hs_a, 32'(!(x >= 656 && x < 752)));
            check_eq("a_l0_line_end", le_a, 32'(x == 799));
            check_eq("a_l0_vs", vs_a, 1);
        end
        $display("txn a_line0: scanned DrawX 2..799 on DrawY 0");

        // Test 3: line wrap 799,5 -> 0,6.
        wait_a(799, 5, "a_l5_end");
        check_eq("a_l5_line_end", le_a, 1);
        check_eq("a_l5_blank", blank_a, 0);
        @(negedge clk);
        check_eq("a_l6_x", x_a, 0);
        check_eq("a_l6_y", y_a, 6);
        check_eq("a_l6_line_end", le_a, 0);
        check_eq("a_l6_blank", blank_a, 1);
        check_eq("a_l6_frame_start", fs_a, 0);
        $display("txn a_line_wrap: (%0d,%0d) line_end=%0b blank=%0b", x_a, y_a, le_a, blank_a);

        // Reset pulse in the middle of an hsync pulse: no partial pulse survives.
        wait_a(700, 7, "a_mid");
        check_eq("a_mid_hs_low", hs_a, 0);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        check_reset_vals("a_mid_reset", x_a, y_a, blank_a, hs_a, vs_a, le_a, fs_a, fc_a);
        @(negedge clk);
        check_eq("a_after_reset_x", x_a, 1);
        check_eq("a_after_reset_hs", hs_a, 1);

        // Small mode: release, then 256 full frames against the model.
        rst_b = 1'b0;
        check_reset_vals("b_release", x_b, y_b, blank_b, hs_b, vs_b, le_b, fs_b, fc_b);
        bx = 0; by = 0; bf = 0;
        for (int i = 0; i < 256 * 120; i++) step_b();
        check_eq("b_fc_256_wrap", fc_b, 0);
        check_eq("b_fc_256_fs", fs_b, 1);
        $display("txn b_256_frames: (%0d,%0d) frame_count=%0d frame_start=%0b", x_b, y_b, fc_b, fs_b);

        // Test 6 analogue: reset at (11,5) with frame_count=3, inside both sync pulses.
        for (int i = 0; i < 1000 && !(bf == 3 && bx == 11 && by == 5); i++) step_b();
        check_eq("b_mid_reached", 32'(x_b == 10'd11 && y_b == 10'd5 && fc_b == 8'd3), 1);
        check_eq("b_mid_hs_low", hs_b, 0);
        check_eq("b_mid_vs_low", vs_b, 0);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        check_reset_vals("b_mid_reset", x_b, y_b, blank_b, hs_b, vs_b, le_b, fs_b, fc_b);
        bx = 0; by = 0; bf = 0;
        for (int i = 0; i < 120 + 5; i++) step_b();
        check_eq("b_post_reset_fc", fc_b, 1);
        $display("txn b_post_reset_frame: (%0d,%0d) frame_count=%0d", x_b, y_b, fc_b);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
